wait_state_sched: RTL and testbench
===================================

// Module: wait_state_sched
// PURPOSE
//  Programmable wait-state sequencer for the 65C02 bus. Per-region wait counts
//  live in a small CPU-writable register file. The block stretches each access by
//  driving RDYn low, and honours the external WSn extend request.
//  Sits beside the address-decode glue, consumes its active-low region strobes, and
//  replaces the fixed single ROM wait state.
// PARAMETERS
//  NUM_REGIONS  4  number of decoded region strobes (0=ROM, 1..3=IOSEL1..3)
//  WAIT_W       3  width of each wait count (0..7 waits)
//  ROM_RST_WS   1  reset wait count for region 0; all other regions reset to 0
//  TIMEOUT      64 max PHI2 cycles a WSn extension may hold the bus (WS_TIMEOUT_EN only)
// PORTS
//  PHI2         in   1   CPU phase-2 clock; all flops are posedge PHI2
//  RESETn       in   1   asynchronous active-low reset
//  REGION_SELn  in   NUM_REGIONS  active-low region strobes from the decoder
//  RWn          in   1   CPU read/write (1 = read)
//  WSn          in   1   external wait request, active low
//  CFG_SEL      in   1   access to the scheduler config window (active high)
//  CFG_ADDR     in   2   config register index (region number)
//  DIN          in   8   CPU data bus in
//  DOUT         out  8   config read data; 0 when not CFG_SEL && RWn
//  WAIT         out  1   internal stall flag (1 while state != IDLE)
//  RDYn         out  1   0 while WAIT, else Z (wired-OR onto the CPU RDY line)
//  TOERR        out  1   sticky WSn-timeout flag (WS_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, WAIT=0, RDYn=Z, TOERR=0.
//   Reset sets ws[0]=ROM_RST_WS and ws[1..]=0. Reset mid-stall releases RDYn immediately.
//  States: IDLE, COUNT, EXT, CFGWR.
//  Decisions are taken on posedge PHI2 only. The address and strobes are stable by then.
//   The CPU samples RDY on negedge PHI2.
//  From IDLE, at posedge, in priority order:
//   CFG_SEL && !RWn -> CFGWR, exactly 1 forced wait. The CPU holds DIN during the stall.
//     DIN[WAIT_W-1:0] is written to ws[CFG_ADDR] on the posedge leaving CFGWR.
//   else the lowest-index asserted strobe selects region r; n = ws[r].
//     No strobe asserted: n = 0.
//   n>0 -> COUNT with cnt=n.
//   n==0 && !WSn -> EXT.
//   otherwise stay in IDLE, with no stall.
//  COUNT: each posedge cnt<=cnt-1. At a posedge with cnt==1:
//   WSn high -> IDLE.
//   WSn low -> EXT.
//   An n-wait access therefore holds RDYn low for exactly n PHI2 cycles.
//  EXT: stay while WSn low. At the first posedge with WSn high -> IDLE.
//  The posedge that returns to IDLE never re-arms a new stall. The next access is
//   evaluated at the following posedge (no double-trigger on one bus cycle).
//  Config reads (CFG_SEL && RWn): DOUT = zero-extended ws[CFG_ADDR], combinational, 0 waits.
//  CFG_ADDR >= NUM_REGIONS: writes are ignored and reads return 0.
//  A write to ws[r] takes effect from the next access. A stall already in progress is
//   unaffected.
//  CFG_SEL with a region strobe also asserted: config takes priority.
// CONFIGURATION
//  WS_TIMEOUT_EN defined: a timeout counter (clog2(TIMEOUT)+1 bits) runs in EXT.
//   After TIMEOUT cycles the block forces IDLE and sets TOERR.
//   TOERR is cleared only by reset or by a config write of any value to index 3.
//   WSn must then go high before EXT can be re-entered.
//  WS_TIMEOUT_EN undefined: EXT is unbounded, TOERR is tied 0, and no counter is built.
// STRUCTURE
//  ws_pkg: state encoding localparams, the region index constants (REG_ROM=0,
//   REG_IO1..3), and the reset-default function.
//  Sub-module ws_cfg_regs: NUM_REGIONS x WAIT_W register file with async reset,
//   a write port, and a combinational read mux.
//  The top level holds the FSM, the down-counter, the timeout, and the RDYn tri-state.
// TESTING
//  1. After reset, read from region 0 -> RDYn low for exactly 1 cycle, then Z.
//     Region 1 read -> no stall.
//  2. Write 5 to ws[2] (1 forced wait), then access region 2 -> RDYn low for 5 cycles.
//     Read back of index 2 returns 8'h05.
//  3. ws[1]=2 and WSn held low for 4 cycles from the access -> COUNT 2 cycles, then EXT.
//     RDYn releases on the first posedge after WSn rises.
//  4. Strobes 0 and 3 asserted together with ws[0]=1, ws[3]=6 -> 1 wait (lowest index wins).
//     CFG_SEL plus a strobe -> config access, 1 wait.
//  5. Assert RESETn low during a 7-wait stall -> RDYn goes Z immediately.
//     Afterwards ws[0]=1 and ws[1..3]=0.
//  6. WS_TIMEOUT_EN, TIMEOUT=64, WSn stuck low -> stall released after 64 cycles, TOERR=1.
//     A write to index 3 clears TOERR.

Source files
------------

// File: rtl/ws_pkg.sv
// Shared types and constants for the 65C02 wait-state sequencer.
// Holds the FSM state encoding, the region index names and the reset-default wait count helper.
package ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EXT   = 2'd2,
    ST_CFGWR = 2'd3
  } ws_state_t;

  localparam int REG_ROM = 0;
  localparam int REG_IO1 = 1;
  localparam int REG_IO2 = 2;
  localparam int REG_IO3 = 3;

  // Only the ROM region carries a wait state out of reset.
  function automatic int ws_reset_default(input int region, input int rom_ws);
    int val;
    case (region)
      REG_ROM:                   val = rom_ws;
      REG_IO1, REG_IO2, REG_IO3: val = 0;
      default:                   val = 0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ws_cfg_regs.sv
// Per-region wait-count register file: one write port and two combinational read ports.
// Port a serves CPU config reads and port b serves the decoded-region lookup.
module ws_cfg_regs
  import ws_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 3,
  parameter int ROM_RST_WS  = 1,
  parameter int ADDR_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WAIT_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WAIT_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WAIT_W-1:0] rdata_b
);

  logic [WAIT_W-1:0] ws_r [NUM_REGIONS];

  // Register file storage; out-of-range indices are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        ws_r[i] <= WAIT_W'(ws_reset_default(i, ROM_RST_WS));
      end
    end else if (we && (int'(waddr) < NUM_REGIONS)) begin
      ws_r[waddr] <= wdata;
    end
  end

  // Read muxes return zero for indices beyond the implemented regions.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (int'(raddr_a) < NUM_REGIONS) rdata_a = ws_r[raddr_a];
    else                             rdata_a = '0;
    if (int'(raddr_b) < NUM_REGIONS) rdata_b = ws_r[raddr_b];
    else                             rdata_b = '0;
  end

endmodule

// File: rtl/wait_state_sched.sv
// Programmable wait-state sequencer: stretches 65C02 accesses by pulling RDYn low per region.
// Optional macro WS_TIMEOUT_EN bounds WSn extensions and reports them on the sticky TOERR flag.
module wait_state_sched
  import ws_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 3,
  parameter int ROM_RST_WS  = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                   PHI2,
  input  logic                   RESETn,
  input  logic [NUM_REGIONS-1:0] REGION_SELn,
  input  logic                   RWn,
  input  logic                   WSn,
  input  logic                   CFG_SEL,
  input  logic [1:0]             CFG_ADDR,
  input  logic [7:0]             DIN,
  output logic [7:0]             DOUT,
  output logic                   WAIT,
  output logic                   RDYn,
  output logic                   TOERR
);

  localparam int ADDR_W = 2;

  if (TIMEOUT < 1 || WAIT_W < 1 || WAIT_W > 7 || NUM_REGIONS > 4) begin : g_bad_cfg
    $error("wait_state_sched: unsupported parameter set");
  end

  ws_state_t         state_r, state_nx;
  logic [WAIT_W-1:0] cnt_r, cnt_nx;
  logic              wait_r;
  logic              cfg_we_s;
  logic [WAIT_W-1:0] cfg_rdata_s, region_ws_s, region_n_s;
  logic [ADDR_W-1:0] region_idx_s;
  logic              region_hit_s;
  logic              tmo_hit_s, ext_blk_s;
  logic              unused_din_s;

  assign unused_din_s = ^DIN[7:WAIT_W];

  ws_cfg_regs #(
    .NUM_REGIONS(NUM_REGIONS),
    .WAIT_W     (WAIT_W),
    .ROM_RST_WS (ROM_RST_WS),
    .ADDR_W     (ADDR_W)
  ) u_regs (
    .clk    (PHI2),
    .rst_n  (RESETn),
    .we     (cfg_we_s),
    .waddr  (CFG_ADDR),
    .wdata  (DIN[WAIT_W-1:0]),
    .raddr_a(CFG_ADDR),
    .rdata_a(cfg_rdata_s),
    .raddr_b(region_idx_s),
    .rdata_b(region_ws_s)
  );

  // Lowest-index asserted strobe wins, so scan from the top down.
  always_comb begin
    region_hit_s = 1'b0;
    region_idx_s = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      region_hit_s = !REGION_SELn[i] ? 1'b1 : region_hit_s;
      region_idx_s = !REGION_SELn[i] ? ADDR_W'(i) : region_idx_s;
    end
  end

  assign region_n_s = region_hit_s ? region_ws_s : '0;

  // Next-state logic; IDLE is the only state that arms a new stall.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    cfg_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (CFG_SEL) begin
          state_nx = RWn ? ST_IDLE : ST_CFGWR;
        end else if (region_n_s != '0) begin
          state_nx = ST_COUNT;
          cnt_nx   = region_n_s;
        end else if (!WSn && !ext_blk_s) begin
          state_nx = ST_EXT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_COUNT: begin
        cnt_nx = cnt_r - WAIT_W'(1);
        if (cnt_r == WAIT_W'(1)) state_nx = (WSn || ext_blk_s) ? ST_IDLE : ST_EXT;
        else                     state_nx = ST_COUNT;
      end
      ST_EXT: begin
        if (WSn || tmo_hit_s) state_nx = ST_IDLE;
        else                  state_nx = ST_EXT;
      end
      ST_CFGWR: begin
        cfg_we_s = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, wait counter and stall flag registers.
  always_ff @(posedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      wait_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      wait_r  <= (state_nx != ST_IDLE);
    end
  end

`ifdef WS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             toerr_r, blk_r;

  assign tmo_hit_s = (state_r == ST_EXT) && (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
  assign ext_blk_s = blk_r;

  // Timeout counter; blk_r keeps a stuck WSn from re-entering EXT until it releases.
  always_ff @(posedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt_r <= '0;
      toerr_r   <= 1'b0;
      blk_r     <= 1'b0;
    end else begin
      tmo_cnt_r <= ((state_r == ST_EXT) && (state_nx == ST_EXT)) ? tmo_cnt_r + TMO_W'(1) : '0;
      if (tmo_hit_s && !WSn) begin
        toerr_r <= 1'b1;
        blk_r   <= 1'b1;
      end else begin
        if (cfg_we_s && (CFG_ADDR == ADDR_W'(REG_IO3))) toerr_r <= 1'b0;
        if (WSn) blk_r <= 1'b0;
      end
    end
  end

  assign TOERR = toerr_r;
`else
  assign tmo_hit_s = 1'b0;
  assign ext_blk_s = 1'b0;
  assign TOERR     = 1'b0;
`endif

  assign WAIT = wait_r;
  assign RDYn = wait_r ? 1'b0 : 1'bz;
  assign DOUT = (CFG_SEL && RWn) ? 8'(cfg_rdata_s) : 8'h00;

endmodule

// File: tb/tb_wait_state_sched.sv
// Scoreboard bench for wait_state_sched: each access pushes its expected stall length
// (and optional read data); a monitor measures the RDYn-low run and compares.
module tb_wait_state_sched;

  typedef struct {
    int         len;
    logic       chk_dout;
    logic [7:0] dout;
  } exp_t;

  logic       phi2, resetn, rwn, wsn, cfg_sel, acc_valid;
  logic [3:0] region_seln;
  logic [1:0] cfg_addr;
  logic [7:0] din, dout;
  logic       stall, toerr;
  wire        rdyn;

  int   checks, errors;
  exp_t exp_q[$];

  pullup (rdyn);

  wait_state_sched #(
    .NUM_REGIONS(4), .WAIT_W(3), .ROM_RST_WS(1), .TIMEOUT(64)
  ) dut (
    .PHI2(phi2), .RESETn(resetn), .REGION_SELn(region_seln), .RWn(rwn), .WSn(wsn),
    .CFG_SEL(cfg_sel), .CFG_ADDR(cfg_addr), .DIN(din), .DOUT(dout),
    .WAIT(stall), .RDYn(rdyn), .TOERR(toerr)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // One bus access: strobes/config for one posedge, WSn low for `hold` posedges.
  task automatic access(input logic [3:0] seln, input logic cs, input logic rw,
                        input logic [1:0] addr, input logic [7:0] data, input int hold,
                        input int exp_len, input logic chk, input logic [7:0] exp_dout);
    exp_t e;
    int   k;
    @(negedge phi2);
    region_seln = seln; cfg_sel = cs; rwn = rw; cfg_addr = addr; din = data;
    wsn = (hold > 0) ? 1'b0 : 1'b1;
    e.len = exp_len; e.chk_dout = chk; e.dout = exp_dout;
    exp_q.push_back(e);
    acc_valid = 1'b1;
    k = 0;
    do begin
      @(posedge phi2);
      #1;
      k++;
      acc_valid = 1'b0; region_seln = 4'hF; cfg_sel = 1'b0; rwn = 1'b1;
      if (k >= hold) wsn = 1'b1;
    end while ((stall || k < hold) && k < 300);
    repeat (2) @(negedge phi2);
  endtask

  // Monitor: measure the stall that follows each marked access and score it.
  initial begin : monitor
    exp_t       e;
    int         n;
    logic [7:0] d;
    logic       low_ok;
    forever begin
      @(posedge phi2);
      if (acc_valid) begin
        d = dout;
        n = 0;
        low_ok = 1'b1;
        @(negedge phi2);
        while (stall && n < 300) begin
          if (rdyn !== 1'b0) low_ok = 1'b0;
          n++;
          @(negedge phi2);
        end
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stall_len", n, e.len);
          check("rdyn_low_then_released", {low_ok, rdyn}, 2'b11);
          if (e.chk_dout) check("dout", d, e.dout);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; acc_valid = 1'b0;
    region_seln = 4'hF; rwn = 1'b1; wsn = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd0; din = 8'h00;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("reset_wait", stall, 1'b0);
    check("reset_rdyn_z", rdyn, 1'b1);
    check("reset_toerr", toerr, 1'b0);
    check("reset_dout", dout, 8'h00);
    @(negedge phi2); resetn = 1'b1;
    @(negedge phi2);

    // ROM default 1 wait, IO regions none
    access(4'b1110, 1'b0, 1'b1, 2'd0, 8'h00, 0, 1, 1'b0, 8'h00);
    access(4'b1101, 1'b0, 1'b1, 2'd0, 8'h00, 0, 0, 1'b0, 8'h00);
    // program ws[2]=5, use it, read back
    access(4'b1111, 1'b1, 1'b0, 2'd2, 8'h05, 0, 1, 1'b0, 8'h00);
    access(4'b1011, 1'b0, 1'b1, 2'd0, 8'h00, 0, 5, 1'b0, 8'h00);
    access(4'b1111, 1'b1, 1'b1, 2'd2, 8'h00, 0, 0, 1'b1, 8'h05);
    // ws[1]=2 then WSn extension: 2 counted + 2 extended
    access(4'b1111, 1'b1, 1'b0, 2'd1, 8'h02, 0, 1, 1'b0, 8'h00);
    access(4'b1101, 1'b0, 1'b1, 2'd0, 8'h00, 4, 4, 1'b0, 8'h00);
    access(4'b1101, 1'b0, 1'b1, 2'd0, 8'h00, 1, 2, 1'b0, 8'h00);
    // no strobe, WSn low 3 cycles: pure extension
    access(4'b1111, 1'b0, 1'b1, 2'd0, 8'h00, 3, 3, 1'b0, 8'h00);
    // upper DIN bits ignored: F9 stores 1
    access(4'b1111, 1'b1, 1'b0, 2'd0, 8'hF9, 0, 1, 1'b0, 8'h00);
    access(4'b1111, 1'b1, 1'b1, 2'd0, 8'h00, 0, 0, 1'b1, 8'h01);
    // config write with strobe 3 active: config wins, 1 wait
    access(4'b0111, 1'b1, 1'b0, 2'd3, 8'h06, 0, 1, 1'b0, 8'h00);
    access(4'b0110, 1'b0, 1'b1, 2'd0, 8'h00, 0, 1, 1'b0, 8'h00);
    access(4'b0111, 1'b0, 1'b1, 2'd0, 8'h00, 0, 6, 1'b0, 8'h00);
    access(4'b1110, 1'b1, 1'b1, 2'd3, 8'h00, 0, 0, 1'b1, 8'h06);
    // reset in the middle of a 7-wait stall
    access(4'b1111, 1'b1, 1'b0, 2'd1, 8'h07, 0, 1, 1'b0, 8'h00);
    @(negedge phi2); region_seln = 4'b1101;
    @(posedge phi2); #1 region_seln = 4'hF;
    repeat (3) @(posedge phi2);
    @(negedge phi2);
    check("mid_stall_rdyn", {stall, rdyn}, 2'b10);
    #1 resetn = 1'b0;
    #1;
    check("reset_mid_stall_release", {stall, rdyn}, 2'b01);
    @(negedge phi2); resetn = 1'b1;
    @(negedge phi2);
    access(4'b1111, 1'b1, 1'b1, 2'd0, 8'h00, 0, 0, 1'b1, 8'h01);
    access(4'b1111, 1'b1, 1'b1, 2'd1, 8'h00, 0, 0, 1'b1, 8'h00);
    access(4'b1111, 1'b1, 1'b1, 2'd2, 8'h00, 0, 0, 1'b1, 8'h00);
    access(4'b1111, 1'b1, 1'b1, 2'd3, 8'h00, 0, 0, 1'b1, 8'h00);

`ifdef WS_TIMEOUT_EN
    access(4'b1111, 1'b0, 1'b1, 2'd0, 8'h00, 100, 64, 1'b0, 8'h00);
    check("toerr_set", toerr, 1'b1);
    access(4'b1111, 1'b1, 1'b0, 2'd3, 8'h00, 0, 1, 1'b0, 8'h00);
    check("toerr_clear", toerr, 1'b0);
`else
    access(4'b1111, 1'b0, 1'b1, 2'd0, 8'h00, 20, 20, 1'b0, 8'h00);
    check("toerr_tied", toerr, 1'b0);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
